// File: rtl/uart_boot_loader.sv
// UART boot loader: holds the SOC in reset, loads a program image over UART 8N1 into
// instruction memory, then releases the SOC and hands the UART pins over to it.
module uart_boot_loader #(
    parameter int unsigned CLOCK_FREQ   = 100000000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned MEMORY_SIZE  = 4096,
    parameter int unsigned BOOT_WAIT    = 100000000,
    parameter int unsigned BYTE_TIMEOUT = 1000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rx,
    output logic                           tx,
    input  logic                           soc_tx,
    output logic                           soc_rx,
    output logic                           soc_rst_n,
    output logic                           mem_we,
    output logic [$clog2(MEMORY_SIZE)-1:0] mem_addr,
    output logic [31:0]                    mem_wdata,
    output logic                           boot_done
);
    localparam int unsigned BAUD_DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_DIV = BAUD_DIV / 2;
    localparam int unsigned CW       = $clog2(BAUD_DIV + 1);
    localparam int unsigned AW       = $clog2(MEMORY_SIZE);
    localparam int unsigned BW       = $clog2(BOOT_WAIT + 1);
    localparam int unsigned GW       = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [7:0]  MAGIC    = 8'hA5;
    localparam logic [7:0]  CH_K     = 8'h4B;
    localparam logic [7:0]  CH_E     = 8'h45;
    localparam logic [7:0]  CH_T     = 8'h54;

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, REPLY, RUN} state_e;

    // rx synchroniser plus one extra stage for falling-edge detection
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver: bit 0 is the start bit (half-period sample), 1..8 data, 9 stop
    logic          rx_busy_q, rx_valid_q, rx_ferr_q, rx_tick;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_data_q;
    assign rx_tick = (rx_bit_q == 4'd0) ? (rx_cnt_q == CW'(HALF_DIV - 1))
                                        : (rx_cnt_q == CW'(BAUD_DIV - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_busy_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            if (!rx_busy_q) begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= '0;
                    rx_bit_q  <= '0;
                end
            end else if (rx_tick) begin
                rx_cnt_q <= '0;
                if (rx_bit_q == 4'd0) begin
                    if (rx_sync_q) rx_busy_q <= 1'b0;
                    else           rx_bit_q  <= 4'd1;
                end else if (rx_bit_q == 4'd9) begin
                    rx_busy_q  <= 1'b0;
                    rx_valid_q <= rx_sync_q;
                    rx_ferr_q  <= !rx_sync_q;
                end else begin
                    rx_data_q <= {rx_sync_q, rx_data_q[7:1]};
                    rx_bit_q  <= rx_bit_q + 4'd1;
                end
            end else begin
                rx_cnt_q <= rx_cnt_q + CW'(1);
            end
        end
    end

    // Transmitter: frame holds data plus stop bit, shifted out LSB first
    logic          tx_busy_q, tx_line_q, tx_start;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [8:0]    tx_frame_q;
    logic [7:0]    reply_byte_q, reply_byte_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy_q  <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_frame_q <= '1;
        end else if (!tx_busy_q) begin
            if (tx_start) begin
                tx_busy_q  <= 1'b1;
                tx_line_q  <= 1'b0;
                tx_cnt_q   <= '0;
                tx_bit_q   <= '0;
                tx_frame_q <= {1'b1, reply_byte_q};
            end
        end else if (tx_cnt_q == CW'(BAUD_DIV - 1)) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
                tx_busy_q <= 1'b0;
                tx_line_q <= 1'b1;
            end else begin
                tx_bit_q   <= tx_bit_q + 4'd1;
                tx_line_q  <= tx_frame_q[0];
                tx_frame_q <= {1'b1, tx_frame_q[8:1]};
            end
        end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
        end
    end

    state_e        state_q, state_d, ret_q, ret_d;
    logic          sent_q, sent_d, mem_we_q, mem_we_d;
    logic          soc_rst_n_q, soc_rst_n_d, boot_done_q, boot_done_d;
    logic [7:0]    csum_q, csum_d;
    logic [15:0]   len_q, len_d, word_cnt_q, word_cnt_d, len_new;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [BW-1:0] boot_cnt_q, boot_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ret_q        <= IDLE;
            reply_byte_q <= '0;
            sent_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            soc_rst_n_q  <= 1'b0;
            boot_done_q  <= 1'b0;
            csum_q       <= '0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_idx_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            boot_cnt_q   <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            reply_byte_q <= reply_byte_d;
            sent_q       <= sent_d;
            mem_we_q     <= mem_we_d;
            soc_rst_n_q  <= soc_rst_n_d;
            boot_done_q  <= boot_done_d;
            csum_q       <= csum_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_idx_q   <= byte_idx_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            boot_cnt_q   <= boot_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        reply_byte_d = reply_byte_q;
        sent_d       = sent_q;
        mem_we_d     = 1'b0;
        csum_d       = csum_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        byte_idx_d   = byte_idx_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        boot_cnt_d   = '0;
        gap_cnt_d    = '0;
        tx_start     = 1'b0;
        len_new      = {rx_data_q, len_q[7:0]};

        // Advance after each strobe, but hold on the last word so the address never wraps
        if (mem_we_q && (word_cnt_q != len_q)) mem_addr_d = mem_addr_q + AW'(1);

        case (state_q)
            IDLE: begin
                boot_cnt_d = boot_cnt_q + BW'(1);
                if (rx_valid_q && (rx_data_q == MAGIC)) begin
                    state_d    = LEN0;
                    csum_d     = '0;
                    word_cnt_d = '0;
                    byte_idx_d = '0;
                    mem_addr_d = '0;
                end else if (boot_cnt_q == BW'(BOOT_WAIT - 1)) begin
                    state_d = RUN;
                end
            end
            LEN0: if (rx_valid_q) begin
                csum_d     = csum_q ^ rx_data_q;
                len_d[7:0] = rx_data_q;
                state_d    = LEN1;
            end
            LEN1: if (rx_valid_q) begin
                csum_d      = csum_q ^ rx_data_q;
                len_d[15:8] = rx_data_q;
                if (32'(len_new) > MEMORY_SIZE) begin
                    state_d      = REPLY;
                    reply_byte_d = CH_E;
                    ret_d        = IDLE;
                end else if (len_new == 16'd0) begin
                    state_d = CSUM;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: if (rx_valid_q) begin
                csum_d      = csum_q ^ rx_data_q;
                mem_wdata_d = {rx_data_q, mem_wdata_q[31:8]};
                byte_idx_d  = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    mem_we_d   = 1'b1;
                    word_cnt_d = word_cnt_q + 16'd1;
                    if (word_cnt_d == len_q) state_d = CSUM;
                end
            end
            CSUM: if (rx_valid_q) begin
                state_d      = REPLY;
                reply_byte_d = (rx_data_q == csum_q) ? CH_K : CH_E;
                ret_d        = (rx_data_q == csum_q) ? RUN : IDLE;
            end
            REPLY: begin
                if (!sent_q) begin
                    tx_start = 1'b1;
                    sent_d   = 1'b1;
                end else if (!tx_busy_q) begin
                    sent_d  = 1'b0;
                    state_d = ret_q;
                end
            end
            RUN: ;
            default: state_d = IDLE;
        endcase

        // Frame-level errors take priority over normal byte handling
        if (state_q inside {LEN0, LEN1, DATA, CSUM}) begin
            gap_cnt_d = rx_valid_q ? '0 : gap_cnt_q + GW'(1);
            if (rx_ferr_q) begin
                state_d      = REPLY;
                reply_byte_d = CH_E;
                ret_d        = IDLE;
            end else if (!rx_valid_q && (gap_cnt_q == GW'(BYTE_TIMEOUT - 1))) begin
                state_d      = REPLY;
                reply_byte_d = CH_T;
                ret_d        = IDLE;
            end
        end

        soc_rst_n_d = (state_d == RUN);
        boot_done_d = (state_d == RUN);
    end

    assign tx        = (state_q == RUN) ? soc_tx : tx_line_q;
    assign soc_rx    = (state_q == RUN) ? rx_sync_q : 1'b1;
    assign soc_rst_n = soc_rst_n_q;
    assign boot_done = boot_done_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule
